mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, ACCESS-state cycles without ack before abort; legal range 1..255.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port start_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port MemRead_i  input  1  load request from EX/MEM pipeline register.
REQ-005 SHALL have port MemWrite_i  input  1  store request from EX/MEM pipeline register.
REQ-006 SHALL have port Addr_i  input  32  memory address, i.e. EX/MEM ALU result.
REQ-007 SHALL have port Wdata_i  input  32  store data.
REQ-008 SHALL have port mem_ack_i  input  1  data memory completion strobe.
REQ-009 SHALL have port mem_rdata_i  input  32  data memory read data, valid with mem_ack_i.
REQ-010 SHALL have port mem_req_o  output  1  memory request, registered.
REQ-011 SHALL have port mem_we_o  output  1  1 = write, 0 = read; registered.
REQ-012 SHALL have port mem_addr_o  output  32  latched address.
REQ-013 SHALL have port mem_wdata_o  output  32  latched store data.
REQ-014 SHALL have port Rdata_o  output  32  captured load data for MEM/WB.
REQ-015 SHALL have port stall_o  output  1  holds PC, IF/ID, ID/EX and EX/MEM registers.
REQ-016 SHALL have port err_o  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS and DONE, plus an 8-bit wait counter.
REQ-018 IDLE: when MemRead_i|MemWrite_i=1, SHALL latch Addr_i and Wdata_i, set mem_we_o=MemWrite_i, set mem_req_o=1, clear the counter and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-019 MemRead_i=MemWrite_i=1 together SHALL be treated as a write; no error is flagged.
REQ-020 ACCESS: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be held stable until the exit edge.
REQ-021 ACCESS with mem_ack_i=1: SHALL capture Rdata_o<=mem_rdata_i when the access is a read, drop mem_req_o and go to DONE.
REQ-022 ACCESS with mem_ack_i=0: SHALL increment the counter; when counter+1==TIMEOUT, SHALL set err_o=1, drop mem_req_o, set Rdata_o<=0 when the access is a read, and go to DONE.
REQ-023 Ack and timeout in the same cycle: ack SHALL win; err_o is unchanged.
REQ-024 DONE: SHALL ignore all requests for one cycle (EX/MEM still holds the finished instruction), then go to IDLE.
REQ-025 stall_o SHALL be combinational: 1 in ACCESS, 1 in IDLE when MemRead_i|MemWrite_i=1, 0 in DONE and otherwise.
REQ-026 Latency: request seen at cycle 0 and ack at cycle k (k>=1) SHALL give stall_o=1 for cycles 0..k and stall_o=0 at cycle k+1 (DONE).
REQ-027 Rdata_o SHALL be valid from DONE onward and held until the next read capture; writes SHALL not modify Rdata_o.
REQ-028 mem_ack_i in IDLE or DONE SHALL be ignored.
REQ-029 err_o SHALL stay set until reset; later accesses SHALL proceed normally.
REQ-030 Back-to-back accesses SHALL be separated by exactly one DONE cycle, with no overlapping requests.

Reset
REQ-031 start_i=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0 and all outputs to 0; stall_o then follows REQ-025.
REQ-032 Reset during ACCESS SHALL abort the access and drop mem_req_o the same cycle; the access is not retried after reset.
REQ-033 Operation SHALL resume on the first posedge after start_i returns to 1.

Verification
REQ-034 Read: Addr_i=0x40 with MemRead_i=1, ack after 3 cycles with rdata 0xDEADBEEF -> mem_addr_o=0x40, mem_we_o=0, stall_o=1 for 4 cycles, Rdata_o=0xDEADBEEF in DONE.
REQ-035 Write: MemWrite_i=1, Wdata_i=0x12345678, ack after 1 cycle -> mem_we_o=1, mem_wdata_o=0x12345678, stall_o=1 for 2 cycles, Rdata_o unchanged.
REQ-036 Timeout: TIMEOUT=4, read with no ack -> mem_req_o drops after 4 ACCESS cycles, err_o=1, Rdata_o=0; a following ack-1 read completes with err_o still 1.
REQ-037 Back-to-back: load followed by store, each acked in 1 cycle -> exactly one DONE cycle between the two mem_req_o pulses, with stall_o=0 only in those DONE cycles.
REQ-038 Reset mid-op: start_i=0 during ACCESS cycle 2 -> mem_req_o and err_o go to 0 asynchronously, state=IDLE; a stray ack after release is ignored.
REQ-039 Edge case: ack on the same cycle the timeout expires (TIMEOUT=2, ack at 2nd ACCESS cycle) -> data captured, err_o=0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns a load/store held in EX/MEM into one request to
// a variable-latency data memory, stalling the front of the pipe until it ends.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] Wdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] Rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [1:0]  state_o
);

  // Memory handshake: mem_req_o acts as valid and stays high, with we/addr/wdata
  // frozen, until the first cycle mem_ack_i is seen high (or the wait times out);
  // mem_ack_i is only meaningful while mem_req_o is high and is ignored otherwise.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  state_t      w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_req_nxt;
  logic        w_we_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_wdata_nxt;
  logic [31:0] w_rdata_nxt;
  logic        w_err_nxt;
  logic        w_stall;
  logic        w_mem_op;
  logic        w_timeout;

  assign w_mem_op  = MemRead_i | MemWrite_i;
  assign w_timeout = ((r_cnt + 8'd1) == TIMEOUT_C);

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_mem_op;
        if (w_mem_op) begin
          // A simultaneous read+write request resolves to a write.
          w_addr_nxt  = Addr_i;
          w_wdata_nxt = Wdata_i;
          w_we_nxt    = MemWrite_i;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        w_stall = 1'b1;
        if (mem_ack_i) begin
          if (!r_we) begin
            w_rdata_nxt = mem_rdata_i;
          end
          w_req_nxt   = 1'b0;
          w_state_nxt = DONE;
        end else if (w_timeout) begin
          if (!r_we) begin
            w_rdata_nxt = 32'd0;
          end
          w_err_nxt   = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      DONE: begin
        // EX/MEM still holds the finished instruction this cycle.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign Rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign stall_o     = w_stall;
  assign state_o     = r_state;

  a_req_only_in_access: assert property (
    @(posedge clk_i) disable iff (!start_i) (r_req == (r_state == ACCESS))
  );

  a_access_outputs_stable: assert property (
    @(posedge clk_i) disable iff (!start_i)
    (r_state == ACCESS) |=> ((r_state != ACCESS) ||
                             ($stable(r_addr) && $stable(r_wdata) && $stable(r_we)))
  );

endmodule
